wb_bus_switch_n: RTL and testbench
==================================

Name: wb_bus_switch_n

Overview:
Parametrised one-master, N-slave Wishbone switch. It is the successor to the fixed 7-slave peripheral and 1-slave memory switches.
- Sits between a BIU bus port (mem or per) and its slaves.
- Decodes a slave index from an address field and registers the slave-side strobes and the master-side response.
- Returns an error response for unmapped slave indices and, optionally, for slaves that do not answer in time.

Parameters:
NUM_SLAVES, 7, number of slave ports (1..16)
DW, 32, data width
AW, 32, address width
SEL_LSB, 8, lowest address bit of slave index field
SEL_BITS, 4, width of slave index field (2**SEL_BITS >= NUM_SLAVES)
TIMEOUT_CYCLES, 255, slave-ack wait limit (used only with timeout feature)
ERR_DATA, 32'hDEADBEEF, read data returned on an error response

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
master_stb_i  in  1  request strobe, held high until master_ack_o
master_we_i  in  1  write enable
master_adr_i  in  AW  address
master_dat_i  in  DW  write data
master_sel_i  in  DW/8  byte selects
master_dat_o  out  DW  read data, registered
master_ack_o  out  1  one-cycle completion pulse
master_err_o  out  1  one-cycle error pulse, coincident with master_ack_o
slave_dat_i  in  NUM_SLAVES*DW  read data, slave k at [k*DW +: DW]
slave_ack_i  in  NUM_SLAVES  per-slave ack
slave_stb_o  out  NUM_SLAVES  one-hot strobe
slave_cyc_o  out  NUM_SLAVES  one-hot cycle, equal to slave_stb_o
slave_we_o  out  1  broadcast we, registered
slave_adr_o  out  AW  broadcast address, registered
slave_dat_o  out  DW  broadcast write data, registered
slave_sel_o  out  DW/8  broadcast byte selects, registered

Behaviour:
- Reset (sync, rst_i=1 at a clock edge): state=IDLE. All outputs go to 0 that edge, including a transaction in flight, which is abandoned. No ack is issued for it.
- FSM states are IDLE, ACTIVE, RESP.
- IDLE:
  - If master_stb_i=1, latch we/adr/dat/sel into slave_* regs and compute idx=master_adr_i[SEL_LSB +: SEL_BITS].
  - If idx < NUM_SLAVES: set slave_stb_o/cyc_o bit idx, clear the timeout counter, go to ACTIVE.
  - Else (unmapped): master_dat_o=ERR_DATA, master_err_o=1, master_ack_o=1, go to RESP. No slave strobe is raised.
- ACTIVE:
  - Strobes held; wait for slave_ack_i[idx].
  - On ack: master_dat_o=slave_dat_i[idx] (also on writes, where master ignores it), master_ack_o=1, master_err_o=0, clear strobes, go to RESP.
  - Acks on non-selected slaves are ignored.
- RESP: master_ack_o/err_o are high for exactly this one cycle; go to IDLE. master_stb_i is not sampled in RESP.
- Master protocol: master deasserts master_stb_i the cycle after master_ack_o. The next request is accepted in IDLE.
- Latency:
  - Slave strobe rises 1 cycle after master_stb_i is sampled in IDLE.
  - master_ack_o rises 1 cycle after slave ack.
  - Minimum transaction is 3 cycles with a same-cycle slave ack.
  - Unmapped access acks 1 cycle after the request (RESP).
- master_dat_o holds its value between transactions; it is cleared only by reset.
- slave_* broadcast regs change only on request acceptance.

Optional Feature:
- Macro: BUS_SWITCH_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each ACTIVE cycle without ack.
  - When the counter == TIMEOUT_CYCLES and there is still no ack: clear strobes, master_dat_o=ERR_DATA, master_err_o=1, master_ack_o=1, go to RESP.
  - An ack arriving in the same cycle as the limit wins: normal response.
- Not defined: no counter exists and ACTIVE waits indefinitely.

Decomposition:
- Package wb_switch_pkg holds:
  - the FSM state enum (IDLE/ACTIVE/RESP)
  - the default ERR_DATA constant
  - a clog2 function
- One natural sub-module, wb_switch_decode: combinational idx extraction, valid flag (idx < NUM_SLAVES), and one-hot generation.
- The FSM, registers and timeout counter stay in the top.

Test Plan:
- NUM_SLAVES=7, read adr 0x0000_0300, slave 3 acks 2 cycles after its stb with dat 0x1234_5678 -> only slave_stb_o[3] high, master_ack_o pulse with master_dat_o=0x1234_5678, err=0, slave_stb_o cleared.
- Write adr 0x0000_0100, dat 0xA5A5_0001, sel 4'b0011, slave 1 acks same cycle -> slave_adr/dat/sel/we broadcast correctly, ack on cycle 3 after request.
- Read adr 0x0000_0F00 (idx 15 ≥ 7) -> no slave strobe, ack+err next cycle, master_dat_o=0xDEADBEEF.
- With BUS_SWITCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave 2 never acks -> ack+err after 8 ACTIVE cycles, strobe dropped. Repeat with ack on the 8th cycle -> normal ack, err=0.
- Assert rst_i for 1 cycle while ACTIVE on slave 4 -> next cycle all outputs 0, no master_ack_o. A subsequent request to slave 0 completes normally.
- Back-to-back: slave 5 then slave 6 requests, stb dropped for 1 cycle between them -> two separate acks, correct data each, no overlap of slave strobes.

Source files
------------

// File: rtl/wb_switch_pkg.sv
// wb_switch_pkg
//   Shared types and constants for the one-master / N-slave Wishbone switch.
//   - sw_state_t       : switch FSM states (IDLE / ACTIVE / RESP)
//   - ERR_DATA_DEFAULT : read data returned with an error response
//   - clog2()          : ceiling log2, used to size the optional timeout counter
package wb_switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } sw_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Returns 1 for v <= 2 so a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/wb_switch_decode.sv
// wb_switch_decode
//   Combinational slave-index decode for wb_bus_switch_n.
//   Ports:
//     sel_field  in  SEL_BITS     address slice holding the slave index
//     idx        out SEL_BITS     decoded slave index
//     valid      out 1            index maps to an existing slave
//     onehot     out NUM_SLAVES   one-hot slave select (all zero when !valid)
module wb_switch_decode #(
    parameter int NUM_SLAVES = 7,
    parameter int SEL_BITS   = 4
) (
    input  logic [SEL_BITS-1:0]   sel_field,
    output logic [SEL_BITS-1:0]   idx,
    output logic                  valid,
    output logic [NUM_SLAVES-1:0] onehot
);

    assign idx   = sel_field;
    assign valid = (32'(sel_field) < 32'(NUM_SLAVES));

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_onehot
        assign onehot[k] = (sel_field == SEL_BITS'(k));
    end

endmodule

// File: rtl/wb_bus_switch_n.sv
// wb_bus_switch_n
//   One master, NUM_SLAVES-slave Wishbone switch. The slave index comes from
//   master_adr_i[SEL_LSB +: SEL_BITS]. Slave-side strobes and broadcast
//   request fields are registered on acceptance; the master response
//   (data/ack/err) is registered and pulses for one cycle in RESP.
//   Unmapped indices get an immediate error response carrying ERR_DATA.
//
//   Optional feature macro: BUS_SWITCH_TIMEOUT_EN
//     defined   -> a slave that does not ack within TIMEOUT_CYCLES counted
//                  ACTIVE cycles is abandoned with an error response
//     undefined -> ACTIVE waits for the slave ack indefinitely
//
//   Ports:
//     clk_i, rst_i          clock, synchronous active-high reset
//     master_*_i / _o       master side (stb/we/adr/dat/sel in, dat/ack/err out)
//     slave_dat_i/ack_i     per-slave read data (k at [k*DW +: DW]) and ack
//     slave_stb_o/cyc_o     one-hot strobe / cycle (identical)
//     slave_we/adr/dat/sel_o broadcast request fields
module wb_bus_switch_n
    import wb_switch_pkg::*;
#(
    parameter int NUM_SLAVES     = 7,
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int SEL_LSB        = 8,
    parameter int SEL_BITS       = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     master_stb_i,
    input  logic                     master_we_i,
    input  logic [AW-1:0]            master_adr_i,
    input  logic [DW-1:0]            master_dat_i,
    input  logic [DW/8-1:0]          master_sel_i,
    output logic [DW-1:0]            master_dat_o,
    output logic                     master_ack_o,
    output logic                     master_err_o,
    input  logic [NUM_SLAVES*DW-1:0] slave_dat_i,
    input  logic [NUM_SLAVES-1:0]    slave_ack_i,
    output logic [NUM_SLAVES-1:0]    slave_stb_o,
    output logic [NUM_SLAVES-1:0]    slave_cyc_o,
    output logic                     slave_we_o,
    output logic [AW-1:0]            slave_adr_o,
    output logic [DW-1:0]            slave_dat_o,
    output logic [DW/8-1:0]          slave_sel_o
);

    sw_state_t state, state_nxt;

    logic [SEL_BITS-1:0]   dec_idx;
    logic                  dec_valid;
    logic [NUM_SLAVES-1:0] dec_onehot;

    wb_switch_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .SEL_BITS  (SEL_BITS)
    ) u_decode (
        .sel_field(master_adr_i[SEL_LSB +: SEL_BITS]),
        .idx      (dec_idx),
        .valid    (dec_valid),
        .onehot   (dec_onehot)
    );

    // The registered one-hot strobe already identifies the selected slave,
    // so masking acks with it ignores acks from every other slave.
    logic          ack_sel;
    logic [DW-1:0] sel_dat;

    assign ack_sel = |(slave_ack_i & slave_stb_o);

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++)
            if (slave_stb_o[k]) sel_dat = slave_dat_i[k*DW +: DW];
    end

    logic tmo_hit;

`ifdef BUS_SWITCH_TIMEOUT_EN
    localparam int TW = clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // An ack in the limit cycle takes priority over the timeout (see FSM).
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i || state != ST_ACTIVE)
            tmo_cnt <= '0;
        else if (!ack_sel && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    // No timeout: the comparison is constant false and only keeps the
    // parameter referenced in this build.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (master_stb_i) state_nxt = dec_valid ? ST_ACTIVE : ST_RESP;
            ST_ACTIVE: if (ack_sel || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            master_dat_o <= '0;
            master_ack_o <= 1'b0;
            master_err_o <= 1'b0;
            slave_stb_o  <= '0;
            slave_we_o   <= 1'b0;
            slave_adr_o  <= '0;
            slave_dat_o  <= '0;
            slave_sel_o  <= '0;
        end else begin
            master_ack_o <= 1'b0;
            master_err_o <= 1'b0;
            case (state)
                ST_IDLE: if (master_stb_i) begin
                    slave_we_o  <= master_we_i;
                    slave_adr_o <= master_adr_i;
                    slave_dat_o <= master_dat_i;
                    slave_sel_o <= master_sel_i;
                    if (dec_valid) begin
                        slave_stb_o <= dec_onehot;
                    end else begin
                        master_dat_o <= ERR_DATA;
                        master_ack_o <= 1'b1;
                        master_err_o <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (ack_sel) begin
                        master_dat_o <= sel_dat;
                        master_ack_o <= 1'b1;
                        slave_stb_o  <= '0;
                    end else if (tmo_hit) begin
                        master_dat_o <= ERR_DATA;
                        master_ack_o <= 1'b1;
                        master_err_o <= 1'b1;
                        slave_stb_o  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign slave_cyc_o = slave_stb_o;

endmodule

// File: tb/tb_wb_bus_switch_n.sv
// tb_wb_bus_switch_n
//   Directed bench for wb_bus_switch_n (7 slaves, 32-bit, TIMEOUT_CYCLES=8).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_bus_switch_n;

    localparam int NS = 7;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              master_stb_i, master_we_i;
    logic [AW-1:0]     master_adr_i;
    logic [DW-1:0]     master_dat_i;
    logic [3:0]        master_sel_i;
    logic [DW-1:0]     master_dat_o;
    logic              master_ack_o, master_err_o;
    logic [NS*DW-1:0]  slave_dat_i;
    logic [NS-1:0]     slave_ack_i;
    logic [NS-1:0]     slave_stb_o, slave_cyc_o;
    logic              slave_we_o;
    logic [AW-1:0]     slave_adr_o;
    logic [DW-1:0]     slave_dat_o;
    logic [3:0]        slave_sel_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    wb_bus_switch_n #(
        .NUM_SLAVES(NS), .DW(DW), .AW(AW), .SEL_LSB(8), .SEL_BITS(4),
        .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .master_stb_i(master_stb_i), .master_we_i(master_we_i),
        .master_adr_i(master_adr_i), .master_dat_i(master_dat_i),
        .master_sel_i(master_sel_i), .master_dat_o(master_dat_o),
        .master_ack_o(master_ack_o), .master_err_o(master_err_o),
        .slave_dat_i(slave_dat_i), .slave_ack_i(slave_ack_i),
        .slave_stb_o(slave_stb_o), .slave_cyc_o(slave_cyc_o),
        .slave_we_o(slave_we_o), .slave_adr_o(slave_adr_o),
        .slave_dat_o(slave_dat_o), .slave_sel_o(slave_sel_o)
    );

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic drive_req(input logic [AW-1:0] adr, input logic we,
                             input logic [DW-1:0] dat, input logic [3:0] sel);
        master_stb_i = 1'b1;
        master_we_i  = we;
        master_adr_i = adr;
        master_dat_i = dat;
        master_sel_i = sel;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        master_stb_i = 1'b0; master_we_i = 1'b0; master_adr_i = '0;
        master_dat_i = '0; master_sel_i = '0; slave_ack_i = '0;
        for (int k = 0; k < NS; k++) slave_dat_i[k*DW +: DW] = 32'h1000_0000 + k;
        slave_dat_i[3*DW +: DW] = 32'h1234_5678;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        total++;
        if ({slave_stb_o, slave_cyc_o, master_ack_o, master_err_o, master_dat_o} !== '0) begin
            $display("FAIL reset_outputs: stb=%b cyc=%b ack=%b err=%b dat=%h, required all 0",
                     slave_stb_o, slave_cyc_o, master_ack_o, master_err_o, master_dat_o);
        end else passed++;
    endtask

    // Slave 3 read, ack 2 cycles after its strobe; a stray ack from slave 2
    // during the wait must be ignored.
    task automatic test_read();
        drive_req(32'h0000_0300, 1'b0, 32'h0, 4'hF);
        tick();
        total++;
        if (slave_stb_o !== 7'b0001000 || slave_cyc_o !== 7'b0001000) begin
            $display("FAIL read_stb: stb=%b cyc=%b, required 0001000", slave_stb_o, slave_cyc_o);
        end else passed++;
        slave_ack_i = 7'b0000100;
        tick();
        total++;
        if (master_ack_o !== 1'b0 || slave_stb_o !== 7'b0001000) begin
            $display("FAIL read_ignore_other_ack: ack=%b stb=%b, required 0 / 0001000",
                     master_ack_o, slave_stb_o);
        end else passed++;
        slave_ack_i = 7'b0001000;
        tick();
        total++;
        if (master_ack_o !== 1'b1 || master_err_o !== 1'b0 || master_dat_o !== 32'h1234_5678
            || slave_stb_o !== '0) begin
            $display("FAIL read_resp: ack=%b err=%b dat=%h stb=%b, required 1 0 12345678 0",
                     master_ack_o, master_err_o, master_dat_o, slave_stb_o);
        end else passed++;
        slave_ack_i = '0;
        master_stb_i = 1'b0;
        tick();
        total++;
        if (master_ack_o !== 1'b0 || master_dat_o !== 32'h1234_5678) begin
            $display("FAIL read_hold: ack=%b dat=%h, required 0 12345678", master_ack_o, master_dat_o);
        end else passed++;
    endtask

    task automatic test_write();
        drive_req(32'h0000_0100, 1'b1, 32'hA5A5_0001, 4'b0011);
        tick();
        total++;
        if (slave_stb_o !== 7'b0000010 || slave_we_o !== 1'b1 || slave_adr_o !== 32'h0000_0100
            || slave_dat_o !== 32'hA5A5_0001 || slave_sel_o !== 4'b0011) begin
            $display("FAIL write_bcast: stb=%b we=%b adr=%h dat=%h sel=%b, required 0000010 1 00000100 a5a50001 0011",
                     slave_stb_o, slave_we_o, slave_adr_o, slave_dat_o, slave_sel_o);
        end else passed++;
        slave_ack_i = 7'b0000010;
        tick();
        total++;
        if (master_ack_o !== 1'b1 || master_err_o !== 1'b0 || master_dat_o !== 32'h1000_0001) begin
            $display("FAIL write_ack: ack=%b err=%b dat=%h, required 1 0 10000001",
                     master_ack_o, master_err_o, master_dat_o);
        end else passed++;
        slave_ack_i = '0;
        master_stb_i = 1'b0;
        tick();
        total++;
        if (master_ack_o !== 1'b0 || slave_adr_o !== 32'h0000_0100) begin
            $display("FAIL write_after: ack=%b adr=%h, required 0 00000100", master_ack_o, slave_adr_o);
        end else passed++;
    endtask

    task automatic test_unmapped();
        drive_req(32'h0000_0F00, 1'b0, 32'h0, 4'hF);
        tick();
        total++;
        if (master_ack_o !== 1'b1 || master_err_o !== 1'b1 || master_dat_o !== 32'hDEADBEEF
            || slave_stb_o !== '0) begin
            $display("FAIL unmapped_resp: ack=%b err=%b dat=%h stb=%b, required 1 1 deadbeef 0",
                     master_ack_o, master_err_o, master_dat_o, slave_stb_o);
        end else passed++;
        master_stb_i = 1'b0;
        tick();
        total++;
        if (master_ack_o !== 1'b0 || master_err_o !== 1'b0 || slave_stb_o !== '0) begin
            $display("FAIL unmapped_after: ack=%b err=%b stb=%b, required 0 0 0",
                     master_ack_o, master_err_o, slave_stb_o);
        end else passed++;
    endtask

`ifdef BUS_SWITCH_TIMEOUT_EN
    // Counter runs 0..TO over the ACTIVE cycles; the error fires in the cycle
    // where it reads TO, so the strobe is seen for TO+1 cycles.
    task automatic test_timeout();
        int n;
        drive_req(32'h0000_0200, 1'b0, 32'h0, 4'hF);
        n = 0;
        tick();
        while (master_ack_o !== 1'b1 && n < 50) begin
            if (slave_stb_o === 7'b0000100) n++;
            tick();
        end
        total++;
        if (n != TO + 1 || master_err_o !== 1'b1 || master_dat_o !== 32'hDEADBEEF
            || slave_stb_o !== '0) begin
            $display("FAIL timeout_err: stb_cycles=%0d err=%b dat=%h stb=%b, required %0d 1 deadbeef 0",
                     n, master_err_o, master_dat_o, slave_stb_o, TO + 1);
        end else passed++;
        master_stb_i = 1'b0;
        tick();
        // Ack delivered in the limit cycle wins over the timeout.
        drive_req(32'h0000_0200, 1'b0, 32'h0, 4'hF);
        tick();
        for (int i = 1; i < TO + 1; i++) tick();
        slave_ack_i = 7'b0000100;
        tick();
        total++;
        if (master_ack_o !== 1'b1 || master_err_o !== 1'b0 || master_dat_o !== 32'h1000_0002) begin
            $display("FAIL timeout_ack_wins: ack=%b err=%b dat=%h, required 1 0 10000002",
                     master_ack_o, master_err_o, master_dat_o);
        end else passed++;
        slave_ack_i = '0;
        master_stb_i = 1'b0;
        tick();
    endtask
`else
    // Without the timeout the switch waits indefinitely; reset clears it.
    task automatic test_timeout();
        int acks;
        acks = 0;
        drive_req(32'h0000_0200, 1'b0, 32'h0, 4'hF);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (master_ack_o !== 1'b0) acks++;
        end
        total++;
        if (acks != 0 || slave_stb_o !== 7'b0000100) begin
            $display("FAIL no_timeout_wait: acks=%0d stb=%b, required 0 0000100", acks, slave_stb_o);
        end else passed++;
        master_stb_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_in_flight();
        drive_req(32'h0000_0400, 1'b1, 32'hCAFE_0004, 4'hF);
        tick();
        total++;
        if (slave_stb_o !== 7'b0010000) begin
            $display("FAIL rst_pre_stb: stb=%b, required 0010000", slave_stb_o);
        end else passed++;
        rst_i = 1'b1;
        tick();
        total++;
        if ({slave_stb_o, slave_cyc_o, slave_we_o, slave_adr_o, slave_dat_o, slave_sel_o,
             master_ack_o, master_err_o, master_dat_o} !== '0) begin
            $display("FAIL rst_in_flight: stb=%b we=%b adr=%h dat=%h ack=%b mdat=%h, required all 0",
                     slave_stb_o, slave_we_o, slave_adr_o, slave_dat_o, master_ack_o, master_dat_o);
        end else passed++;
        rst_i = 1'b0;
        master_stb_i = 1'b0;
        tick();
        total++;
        if (master_ack_o !== 1'b0 || slave_stb_o !== '0) begin
            $display("FAIL rst_no_ack: ack=%b stb=%b, required 0 0", master_ack_o, slave_stb_o);
        end else passed++;
        drive_req(32'h0000_0000, 1'b0, 32'h0, 4'hF);
        tick();
        slave_ack_i = 7'b0000001;
        tick();
        total++;
        if (master_ack_o !== 1'b1 || master_err_o !== 1'b0 || master_dat_o !== 32'h1000_0000) begin
            $display("FAIL rst_then_s0: ack=%b err=%b dat=%h, required 1 0 10000000",
                     master_ack_o, master_err_o, master_dat_o);
        end else passed++;
        slave_ack_i = '0;
        master_stb_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int multi;
        multi = 0;
        drive_req(32'h0000_0500, 1'b0, 32'h0, 4'hF);
        tick();
        if ($countones(slave_stb_o) > 1) multi++;
        slave_ack_i = 7'b0100000;
        tick();
        total++;
        if (master_ack_o !== 1'b1 || master_dat_o !== 32'h1000_0005 || slave_stb_o !== '0) begin
            $display("FAIL b2b_first: ack=%b dat=%h stb=%b, required 1 10000005 0",
                     master_ack_o, master_dat_o, slave_stb_o);
        end else passed++;
        slave_ack_i = '0;
        master_stb_i = 1'b0;
        tick();
        drive_req(32'h0000_0600, 1'b0, 32'h0, 4'hF);
        tick();
        if ($countones(slave_stb_o) > 1) multi++;
        total++;
        if (slave_stb_o !== 7'b1000000 || master_ack_o !== 1'b0) begin
            $display("FAIL b2b_second_stb: stb=%b ack=%b, required 1000000 0", slave_stb_o, master_ack_o);
        end else passed++;
        slave_ack_i = 7'b1000000;
        tick();
        total++;
        if (master_ack_o !== 1'b1 || master_dat_o !== 32'h1000_0006 || multi != 0) begin
            $display("FAIL b2b_second: ack=%b dat=%h overlaps=%0d, required 1 10000006 0",
                     master_ack_o, master_dat_o, multi);
        end else passed++;
        slave_ack_i = '0;
        master_stb_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_reset_in_flight();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
